// File: rtl/load_pacer.sv
// load_pacer: one-word buffer that releases data on a programmable tick with a nonzero sequence number
module load_pacer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [5:0]       period,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [5:0]       count,
  output logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             underrun
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]       state;
  logic [5:0]       timer;
  logic [5:0]       seq;
  logic             buf_full;
  logic [WIDTH-1:0] buf_q;
  logic             due;
  logic             rel;
  assign due       = state == RUN && timer == 6'd0;
  assign rel       = due && buf_full;
  assign din_ready = !buf_full;
  assign busy      = state == RUN;
  // Single-entry buffer: fills on handshake, drains only on release
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      buf_full <= 1'b0;
      buf_q    <= '0;
    end else if (din_valid && din_ready) begin
      buf_full <= 1'b1;
      buf_q    <= din;
    end else if (rel) begin
      buf_full <= 1'b0;
    end
  // Registered outputs: count pulses the sequence number only on release, d holds between releases
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count    <= '0;
      d        <= '0;
      underrun <= 1'b0;
    end else begin
      count    <= rel ? seq : 6'd0;
      underrun <= due && !buf_full;
      if (rel) d <= buf_q;
    end
  // Run/idle control with tick timer and wrapping sequence number that never hits zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      timer <= '0;
      seq   <= 6'd1;
    end else if (state == IDLE) begin
      if (start) begin
        state <= RUN;
        timer <= period;
        seq   <= 6'd1;
      end
    end else begin
      if (stop) state <= IDLE;
      if (rel) begin
        timer <= period;
        seq   <= seq == 6'd63 ? 6'd1 : 6'(seq + 6'd1);
      end else if (timer != 6'd0) begin
        timer <= 6'(timer - 6'd1);
      end
    end
endmodule

// File: tb/tb_load_pacer.sv
// tb_load_pacer: scoreboard bench for load_pacer
module tb_load_pacer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [5:0] period = '0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [5:0] count;
  logic [7:0] d;
  logic       busy;
  logic       underrun;
  int npass = 0;
  int ntot = 0;
  int nrel = 0;
  int nund = 0;
  int ncyc = 0;
  int exp_seq = 1;
  logic [7:0] q[$];
  always #5 clk = ~clk;
  always @(posedge clk) ncyc++;
  load_pacer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .period(period),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .count(count), .d(d), .busy(busy), .underrun(underrun)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] v);
    bit ok = 1'b0;
    din = v;
    din_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = din_ready;
      cyc(1);
    end
    din_valid = 1'b0;
    chk("send_accept", 32'(ok), 1);
    if (ok) q.push_back(v);
  endtask
  always @(negedge clk)
    if (reset) begin
      if (underrun) nund++;
      if (count != 6'd0) begin
        nrel++;
        if (q.size() == 0) chk("spurious_release", 32'(count), 0);
        else begin
          chk("rel_seq", 32'(count), 32'(exp_seq));
          chk("rel_data", 32'(d), 32'(q.pop_front()));
          exp_seq = exp_seq == 63 ? 1 : exp_seq + 1;
        end
      end
    end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t0;
    int n0;
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_d", 32'(d), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_ready", 32'(din_ready), 1);
    reset = 1'b1;
    cyc(1);
    period = 6'd3;
    start = 1'b1;
    exp_seq = 1;
    send(8'hA5);
    start = 1'b0;
    cyc(3);
    chk("t2_early_count", 32'(count), 0);
    chk("t2_early_nrel", 32'(nrel), 0);
    cyc(1);
    chk("t2_count", 32'(count), 1);
    chk("t2_d", 32'(d), 32'hA5);
    period = 6'd0;
    cyc(1);
    chk("t2_after_count", 32'(count), 0);
    chk("t2_busy", 32'(busy), 1);
    t0 = ncyc;
    for (int i = 0; i < 100; i++) send(8'(i));
    chk("t3_throughput", 32'((ncyc - t0) <= 210), 1);
    for (int i = 0; i < 10 && q.size() != 0; i++) cyc(1);
    chk("t3_drain", 32'(q.size()), 0);
    chk("t3_nrel", 32'(nrel), 101);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(2);
    chk("t4_idle", 32'(busy), 0);
    period = 6'd2;
    start = 1'b1;
    exp_seq = 1;
    nund = 0;
    cyc(1);
    start = 1'b0;
    cyc(9);
    send(8'h3C);
    chk("t4_underrun_due", 32'(underrun), 1);
    cyc(1);
    chk("t4_count", 32'(count), 1);
    chk("t4_d", 32'(d), 32'h3C);
    chk("t4_underrun_rel", 32'(underrun), 0);
    chk("t4_nund", 32'(nund), 8);
    send(8'h5A);
    cyc(1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("t5_count", 32'(count), 2);
    chk("t5_d", 32'(d), 32'h5A);
    chk("t5_busy", 32'(busy), 0);
    cyc(1);
    n0 = nrel;
    send(8'h77);
    cyc(6);
    chk("t5_no_release", 32'(nrel), 32'(n0));
    chk("t5_buffered", 32'(din_ready), 0);
    chk("t5_idle", 32'(busy), 0);
    period = 6'd1;
    start = 1'b1;
    stop = 1'b1;
    exp_seq = 1;
    cyc(1);
    start = 1'b0;
    stop = 1'b0;
    chk("t6_run", 32'(busy), 1);
    cyc(2);
    chk("t6_count", 32'(count), 1);
    chk("t6_d", 32'(d), 32'h77);
    start = 1'b1;
    send(8'h88);
    start = 1'b0;
    cyc(1);
    chk("t6_start_ignored_count", 32'(count), 2);
    chk("t6_d2", 32'(d), 32'h88);
    send(8'h99);
    #2;
    reset = 1'b0;
    #1;
    chk("t1_count", 32'(count), 0);
    chk("t1_d", 32'(d), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_ready", 32'(din_ready), 1);
    chk("t1_underrun", 32'(underrun), 0);
    q.delete();
    exp_seq = 1;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    period = 6'd0;
    start = 1'b1;
    send(8'hC3);
    start = 1'b0;
    cyc(1);
    chk("t1_restart_count", 32'(count), 1);
    chk("t1_restart_d", 32'(d), 32'hC3);
    cyc(3);
    chk("end_queue", 32'(q.size()), 0);
    chk("end_nrel", 32'(nrel), 106);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
